// File: rtl/bus_transfer_ctrl_if.sv
// Command handshake and bus-side signal bundle for bus_transfer_ctrl.
// slave = the controller, master = command source plus bus/register bank.
interface bus_transfer_ctrl_if #(
  parameter int SEL_W = 5
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [SEL_W-1:0]     cmd_src;
  logic [SEL_W-1:0]     cmd_dst;
  logic [31:0]          bus_in;
  logic [SEL_W-1:0]     reg_out_select;
  logic                 bus_drive;
  logic [2**SEL_W-1:0]  dst_load;
  logic [31:0]          xfer_data;
  logic                 done;
  logic                 cmd_error;
  logic                 busy;

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst, bus_in,
    output cmd_ready, reg_out_select, bus_drive, dst_load, xfer_data, done, cmd_error, busy
  );

  modport master (
    output cmd_valid, cmd_src, cmd_dst, bus_in,
    input  cmd_ready, reg_out_select, bus_drive, dst_load, xfer_data, done, cmd_error, busy
  );
endinterface

// File: rtl/bus_transfer_ctrl.sv
// Queues src->dst moves and sequences bus select (DRIVE) then destination load (LATCH).
// Accept-to-done is 3 cycles, one transfer per 2 cycles; cmd_ready drops only when the FIFO is full.
module bus_transfer_ctrl #(
  parameter int SEL_W    = 5,
  parameter int DEPTH    = 2,
  parameter int MAX_CODE = 22
) (
  input  logic              clk,
  input  logic              reset,
  bus_transfer_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int NL = 2**SEL_W;
  localparam logic [SEL_W-1:0] MAX_SEL  = SEL_W'(MAX_CODE);
  localparam logic [NL-1:0]    LOAD_ONE = NL'(1);

  typedef struct packed {
    logic [SEL_W-1:0] src;
    logic [SEL_W-1:0] dst;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, DRIVE, LATCH} state_t;

  cmd_t             mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  state_t           state_q;
  logic [SEL_W-1:0] dst_q;
  logic [SEL_W-1:0] sel_q;
  logic             drive_q;
  logic [NL-1:0]    load_q;
  logic [31:0]      xfer_q;
  logic             done_q;
  logic             err_q;

  logic full, empty, accept, cmd_ok, push, pop;
  cmd_t head;

  // Extra pointer MSB separates the full and empty cases when the indices match.
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign accept = bus.cmd_valid && !full;
  assign cmd_ok = (bus.cmd_src <= MAX_SEL) && (bus.cmd_dst <= MAX_SEL);
  assign push   = accept && cmd_ok;
  assign pop    = !empty && ((state_q == IDLE) || (state_q == LATCH));
  assign head   = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = wr_ptr_q + (AW+1)'(push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{src: bus.cmd_src, dst: bus.cmd_dst};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dst_q   <= '0;
      sel_q   <= '0;
      drive_q <= 1'b0;
      load_q  <= '0;
      xfer_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= accept && !cmd_ok;
      case (state_q)
        IDLE: begin
          if (!empty) begin
            state_q <= DRIVE;
            dst_q   <= head.dst;
            sel_q   <= head.src;
            drive_q <= 1'b1;
          end
        end
        DRIVE: begin
          state_q <= LATCH;
          load_q  <= LOAD_ONE << dst_q;
        end
        LATCH: begin
          xfer_q <= bus.bus_in;
          done_q <= 1'b1;
          load_q <= '0;
          // Chain straight into the next DRIVE so back-to-back moves take 2 cycles each.
          if (!empty) begin
            state_q <= DRIVE;
            dst_q   <= head.dst;
            sel_q   <= head.src;
          end else begin
            state_q <= IDLE;
            drive_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready      = !full;
  assign bus.reg_out_select = sel_q;
  assign bus.bus_drive      = drive_q;
  assign bus.dst_load       = load_q;
  assign bus.xfer_data      = xfer_q;
  assign bus.done           = done_q;
  assign bus.cmd_error      = err_q;
  assign bus.busy           = !empty || (state_q != IDLE);
endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Bench for bus_transfer_ctrl: vector table, directed corner sequences, and a randomized
// run checked against an in-order register-move model driving a behavioural register bank.
module tb_bus_transfer_ctrl;
  localparam int SEL_W = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_transfer_ctrl_if #(.SEL_W(SEL_W)) ifc ();

  bus_transfer_ctrl #(.SEL_W(SEL_W), .DEPTH(2), .MAX_CODE(22)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [4:0]  src;
    logic [4:0]  dst;
    logic [31:0] bval;
    logic        exp_err;
    logic [31:0] exp_load;
    logic [31:0] exp_xfer;
  } vec_t;

  typedef struct {
    int          dst;
    logic [31:0] data;
  } exp_t;

  vec_t        vecs [7];
  exp_t        exp_q [$];
  int          done_cyc [$];
  logic [31:0] mdl  [32];
  logic [31:0] seed [32];
  logic [31:0] bank [32];
  logic        use_bank  = 1'b0;
  logic        load_bank = 1'b0;
  logic        sb_en     = 1'b0;
  logic [31:0] bus_val   = 32'h0;
  int          last_dst  = -1;

  // Behavioural register bank behind the bus mux: drives the selected register, loads on dst_load.
  assign ifc.bus_in = use_bank ? (ifc.bus_drive ? bank[ifc.reg_out_select] : 32'h0) : bus_val;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 32; k++) begin
      if (load_bank) bank[k] <= seed[k];
      else if (use_bank && ifc.dst_load[k]) bank[k] <= ifc.bus_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A legal move copies the source register into the destination, in command order.
  task automatic model_push(input logic [4:0] s, input logic [4:0] d);
    exp_t e;
    if (s <= 5'd22 && d <= 5'd22) begin
      e.dst  = int'(d);
      e.data = mdl[s];
      exp_q.push_back(e);
      mdl[d] = mdl[s];
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic push_cmd(input logic [4:0] s, input logic [4:0] d, output int acc);
    int guard;
    guard = 0;
    ifc.cmd_src   = s;
    ifc.cmd_dst   = d;
    ifc.cmd_valid = 1'b1;
    while (ifc.cmd_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      total++;
      bad++;
      $display("FAIL push_timeout: cmd_ready=%b, required 1 within 50 cycles", ifc.cmd_ready);
    end else if (sb_en) begin
      model_push(s, d);
    end
    @(negedge clk);
    acc = cyc;
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || ifc.busy !== 1'b0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    chkb({name, "_busy"}, ifc.busy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (sb_en && !reset) begin
      chkb("sb_onehot", ($countones(ifc.dst_load) <= 1), 1'b1);
      for (int k = 0; k < 32; k++) if (ifc.dst_load[k]) last_dst = k;
      if (ifc.done === 1'b1) begin
        done_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_spurious_done: done=1 with no transfer outstanding, required 0");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_dst", 32'(last_dst), 32'(e.dst));
          chk("sb_data", ifc.xfer_data, e.data);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: run still active, required to finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int acc, acc0;
    logic [4:0] s, d;

    vecs[0] = '{5'd20, 5'd5,  32'h0000_1234, 1'b0, 32'h0000_0020, 32'h0000_1234};
    vecs[1] = '{5'd3,  5'd3,  32'hDEAD_BEEF, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF};
    vecs[2] = '{5'd0,  5'd22, 32'h0055_AA00, 1'b0, 32'h0040_0000, 32'h0055_AA00};
    vecs[3] = '{5'd22, 5'd0,  32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[4] = '{5'd23, 5'd1,  32'h1111_1111, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[5] = '{5'd1,  5'd31, 32'h2222_2222, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[6] = '{5'd31, 5'd31, 32'h3333_3333, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF};

    ifc.cmd_valid = 1'b0;
    ifc.cmd_src   = '0;
    ifc.cmd_dst   = '0;

    #2;
    chk ("rst_sel",  32'(ifc.reg_out_select), 32'd0);
    chkb("rst_drive", ifc.bus_drive, 1'b0);
    chk ("rst_load", ifc.dst_load, 32'd0);
    chk ("rst_xfer", ifc.xfer_data, 32'd0);
    chkb("rst_done", ifc.done, 1'b0);
    chkb("rst_err",  ifc.cmd_error, 1'b0);
    chkb("rst_busy", ifc.busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chkb("rst_ready", ifc.cmd_ready, 1'b1);

    // Single-command vectors with cycle-exact output checks.
    foreach (vecs[i]) begin
      bus_val       = vecs[i].bval;
      ifc.cmd_src   = vecs[i].src;
      ifc.cmd_dst   = vecs[i].dst;
      chkb("t_ready", ifc.cmd_ready, 1'b1);
      ifc.cmd_valid = 1'b1;
      @(negedge clk);
      ifc.cmd_valid = 1'b0;
      for (int k = 0; k <= 4; k++) begin
        case (k)
          0: begin
            chkb("t0_err",   ifc.cmd_error, vecs[i].exp_err);
            chkb("t0_busy",  ifc.busy, !vecs[i].exp_err);
            chkb("t0_drive", ifc.bus_drive, 1'b0);
          end
          1: begin
            chkb("t1_drive", ifc.bus_drive, !vecs[i].exp_err);
            chk ("t1_load",  ifc.dst_load, 32'd0);
            chkb("t1_err",   ifc.cmd_error, 1'b0);
            if (!vecs[i].exp_err) chk("t1_sel", 32'(ifc.reg_out_select), 32'(vecs[i].src));
          end
          2: begin
            chkb("t2_drive", ifc.bus_drive, !vecs[i].exp_err);
            chk ("t2_load",  ifc.dst_load, vecs[i].exp_load);
            chkb("t2_done",  ifc.done, 1'b0);
            if (!vecs[i].exp_err) chk("t2_sel", 32'(ifc.reg_out_select), 32'(vecs[i].src));
          end
          3: begin
            chkb("t3_done",  ifc.done, !vecs[i].exp_err);
            chk ("t3_xfer",  ifc.xfer_data, vecs[i].exp_xfer);
            chk ("t3_load",  ifc.dst_load, 32'd0);
            chkb("t3_drive", ifc.bus_drive, 1'b0);
            chkb("t3_busy",  ifc.busy, 1'b0);
            if (!vecs[i].exp_err) chk("t3_sel_hold", 32'(ifc.reg_out_select), 32'(vecs[i].src));
          end
          default: begin
            chkb("t4_done", ifc.done, 1'b0);
            chkb("t4_err",  ifc.cmd_error, 1'b0);
          end
        endcase
        @(negedge clk);
      end
    end

    // Reset during the LATCH cycle of a queued pair.
    bus_val = 32'hCAFE_0001;
    push_cmd(5'd1, 5'd2, acc);
    push_cmd(5'd4, 5'd6, acc);
    begin
      int guard;
      guard = 0;
      while (ifc.dst_load == 32'd0 && guard < 10) begin
        @(negedge clk);
        guard++;
      end
      chk("rl_load_seen", ifc.dst_load, 32'h0000_0004);
    end
    reset = 1'b1;
    #1;
    chk ("rl_load_async", ifc.dst_load, 32'd0);
    chkb("rl_drive_async", ifc.bus_drive, 1'b0);
    chkb("rl_busy_async", ifc.busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chkb("rl_no_done", ifc.done, 1'b0);
    end
    chkb("rl_busy",  ifc.busy, 1'b0);
    chkb("rl_ready", ifc.cmd_ready, 1'b1);
    chk ("rl_load",  ifc.dst_load, 32'd0);

    // Register bank and model start from the same random contents.
    for (int k = 0; k < 32; k++) begin
      seed[k] = $urandom;
      mdl[k]  = seed[k];
    end
    load_bank = 1'b1;
    @(negedge clk);
    load_bank = 1'b0;
    use_bank  = 1'b1;
    sb_en     = 1'b1;

    // Back-to-back pushes: FIFO fills, then completions every 2 cycles in order.
    done_cyc.delete();
    push_cmd(5'd20, 5'd5, acc0);
    push_cmd(5'd5,  5'd7, acc);
    push_cmd(5'd7,  5'd20, acc);
    chkb("bb_ready_full", ifc.cmd_ready, 1'b0);
    push_cmd(5'd21, 5'd21, acc);
    wait_drain("bb");
    chk("bb_done_count", 32'(done_cyc.size()), 32'd4);
    if (done_cyc.size() >= 4) begin
      chk("bb_latency", 32'(done_cyc[0] - acc0), 32'd3);
      for (int k = 1; k < 4; k++) chk("bb_spacing", 32'(done_cyc[k] - done_cyc[k-1]), 32'd2);
    end

    // Randomized fill/drain with random gaps; pointers wrap many times.
    for (int i = 0; i < 20; i++) begin
      s = 5'($urandom_range(0, 22));
      d = 5'($urandom_range(0, 22));
      push_cmd(s, d, acc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain("rnd");
    chkb("rnd_ready", ifc.cmd_ready, 1'b1);
    chkb("rnd_err",   ifc.cmd_error, 1'b0);
    for (int k = 0; k <= 22; k++) chk("rnd_bank", bank[k], mdl[k]);

    sb_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
